light_output_stage: RTL and testbench

Output-side counterpart to the input synchronizer in the traffic light controller. It accepts lamp commands from the controller FSM over a valid/ready handshake and drives registered lamp outputs for the main road, side road and pedestrian signal. It enforces an all-red clearance interval before granting a new approach, generates the flashing-walk cadence and flags conflicting commands.

---
 rtl/light_output_stage.sv | 201 ++++++++++++++++++++
 tb/tb_light_output_stage.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/light_output_stage.sv
// light_output_stage: lamp driver for the traffic light controller.
// Takes lamp commands over a valid/ready handshake and drives the main, side and
// pedestrian lamps. An all-red clearance runs before any approach is granted while
// another approach is still lit. The flashing-walk cadence is generated here, and a
// command that grants both approaches at once is rejected and flagged.
// Optional feature macro: LIGHT_LAMP_TEST_EN adds the Lamp_Test input, which forces
// every lamp on while the block is idle.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// ST_IDLE  | hold the stored lamps; Cmd_Ready=1 unless lamp test is active
// ST_CLEAR | all-red clearance; pending command applied when the timer expires
`timescale 1ns/1ps
module light_output_stage #(
  parameter int unsigned ALLRED_CYCLES = 4,
  parameter int unsigned BLINK_HALF    = 2
) (
  input  logic       clk,
  input  logic       Reset_n,
`ifdef LIGHT_LAMP_TEST_EN
  input  logic       Lamp_Test,
`endif
  input  logic       Cmd_Valid,
  output logic       Cmd_Ready,
  input  logic [1:0] Cmd_Main,
  input  logic [1:0] Cmd_Side,
  input  logic [1:0] Cmd_Walk,
  output logic       Main_R,
  output logic       Main_Y,
  output logic       Main_G,
  output logic       Side_R,
  output logic       Side_Y,
  output logic       Side_G,
  output logic       Walk_On,
  output logic       DontWalk_On,
  output logic       Conflict_Err
);

  localparam int CLR_W = $clog2(ALLRED_CYCLES + 1);
  localparam int BLK_W = $clog2(BLINK_HALF + 1);

  localparam logic [1:0] LAMP_RED    = 2'b00;
  localparam logic [1:0] LAMP_GREEN  = 2'b01;
  localparam logic [1:0] LAMP_YELLOW = 2'b10;
  localparam logic [1:0] WALK_DONT   = 2'b00;
  localparam logic [1:0] WALK_STEADY = 2'b01;
  localparam logic [1:0] WALK_FLASH  = 2'b10;

  typedef enum logic {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_main, r_side, r_walk;
  logic [1:0]       r_pend_main, r_pend_side, r_pend_walk;
  logic [CLR_W-1:0] r_clr_cnt;
  logic [BLK_W-1:0] r_blk_cnt;
  logic             r_blink_ph;
  logic             r_err;

  logic       w_lamp_test, w_clear, w_accept, w_conflict, w_interlock, w_cur_busy;
  logic       w_apply_cmd, w_apply_pend, w_apply_any, w_load_clr, w_set_err;
  logic [1:0] w_cmd_main, w_cmd_side, w_cmd_walk;
  logic [1:0] w_new_main, w_new_side, w_new_walk;

  // Reserved codes collapse to the safe state so storage only ever holds legal codes.
  assign w_cmd_main = (Cmd_Main == 2'b11) ? LAMP_RED  : Cmd_Main;
  assign w_cmd_side = (Cmd_Side == 2'b11) ? LAMP_RED  : Cmd_Side;
  assign w_cmd_walk = (Cmd_Walk == 2'b11) ? WALK_DONT : Cmd_Walk;

  assign w_clear = (r_state == ST_CLEAR);
`ifdef LIGHT_LAMP_TEST_EN
  assign w_lamp_test = Lamp_Test & ~w_clear;
`else
  assign w_lamp_test = 1'b0;
`endif

  assign Cmd_Ready  = ~w_clear & ~w_lamp_test;
  assign w_accept   = Cmd_Valid & Cmd_Ready;
  assign w_conflict = (w_cmd_main != LAMP_RED) && (w_cmd_side != LAMP_RED);
  assign w_cur_busy = (r_main != LAMP_RED) || (r_side != LAMP_RED);
  // Clearance is needed only when a red approach is about to be granted while
  // some approach is still showing green or yellow.
  assign w_interlock = w_cur_busy &&
                       (((r_main == LAMP_RED) && (w_cmd_main != LAMP_RED)) ||
                        ((r_side == LAMP_RED) && (w_cmd_side != LAMP_RED)));

  // Next-state and control strobes.
  always_comb begin
    w_state_nxt  = r_state;
    w_apply_cmd  = 1'b0;
    w_apply_pend = 1'b0;
    w_load_clr   = 1'b0;
    w_set_err    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_conflict) begin
            w_set_err = 1'b1;
          end else if (w_interlock) begin
            w_state_nxt = ST_CLEAR;
            w_load_clr  = 1'b1;
          end else begin
            w_apply_cmd = 1'b1;
          end
        end
      end
      ST_CLEAR: begin
        if (r_clr_cnt == '0) begin
          w_state_nxt  = ST_IDLE;
          w_apply_pend = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_apply_any = w_apply_cmd | w_apply_pend;
  assign w_new_main  = w_apply_pend ? r_pend_main : w_cmd_main;
  assign w_new_side  = w_apply_pend ? r_pend_side : w_cmd_side;
  assign w_new_walk  = w_apply_pend ? r_pend_walk : w_cmd_walk;

  // State register.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Stored lamp commands; only change on an apply.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_main <= LAMP_RED;
      r_side <= LAMP_RED;
      r_walk <= WALK_DONT;
    end else if (w_apply_any) begin
      r_main <= w_new_main;
      r_side <= w_new_side;
      r_walk <= w_new_walk;
    end
  end

  // Command held back while the clearance runs.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_pend_main <= LAMP_RED;
      r_pend_side <= LAMP_RED;
      r_pend_walk <= WALK_DONT;
    end else if (w_load_clr) begin
      r_pend_main <= w_cmd_main;
      r_pend_side <= w_cmd_side;
      r_pend_walk <= w_cmd_walk;
    end
  end

  // Clearance down-counter; expiry at zero gives exactly ALLRED_CYCLES all-red cycles.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_clr_cnt <= '0;
    end else if (w_load_clr) begin
      r_clr_cnt <= CLR_W'(ALLRED_CYCLES - 1);
    end else if (w_clear && (r_clr_cnt != '0)) begin
      r_clr_cnt <= r_clr_cnt - CLR_W'(1);
    end
  end

  // Flashing-walk cadence; every apply restarts the phase with the lamp lit.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_blk_cnt  <= '0;
      r_blink_ph <= 1'b0;
    end else if (w_apply_any) begin
      r_blk_cnt  <= '0;
      r_blink_ph <= 1'b1;
    end else if (r_walk == WALK_FLASH) begin
      if (r_blk_cnt == BLK_W'(BLINK_HALF - 1)) begin
        r_blk_cnt  <= '0;
        r_blink_ph <= ~r_blink_ph;
      end else begin
        r_blk_cnt <= r_blk_cnt + BLK_W'(1);
      end
    end
  end

  // Sticky conflict flag.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n)       r_err <= 1'b0;
    else if (w_set_err) r_err <= 1'b1;
  end

  assign Conflict_Err = r_err;
  assign Main_R = w_lamp_test | w_clear | (r_main == LAMP_RED);
  assign Main_Y = w_lamp_test | (~w_clear & (r_main == LAMP_YELLOW));
  assign Main_G = w_lamp_test | (~w_clear & (r_main == LAMP_GREEN));
  assign Side_R = w_lamp_test | w_clear | (r_side == LAMP_RED);
  assign Side_Y = w_lamp_test | (~w_clear & (r_side == LAMP_YELLOW));
  assign Side_G = w_lamp_test | (~w_clear & (r_side == LAMP_GREEN));
  assign Walk_On = w_lamp_test |
                   (~w_clear & ((r_walk == WALK_STEADY) ||
                                ((r_walk == WALK_FLASH) && r_blink_ph)));
  assign DontWalk_On = w_lamp_test | w_clear | (r_walk == WALK_DONT);

endmodule

// File: tb/tb_light_output_stage.sv
// tb_light_output_stage: directed checks of light_output_stage with the default
// parameters (ALLRED_CYCLES=4, BLINK_HALF=2).
// Lamp vector order: {Main_R,Main_Y,Main_G,Side_R,Side_Y,Side_G,Walk_On,DontWalk_On}.
`timescale 1ns/1ps
module tb_light_output_stage;

  logic       clk = 1'b0;
  logic       Reset_n;
  logic       Cmd_Valid;
  logic       Cmd_Ready;
  logic [1:0] Cmd_Main, Cmd_Side, Cmd_Walk;
  logic       Main_R, Main_Y, Main_G, Side_R, Side_Y, Side_G, Walk_On, DontWalk_On;
  logic       Conflict_Err;
`ifdef LIGHT_LAMP_TEST_EN
  logic       Lamp_Test = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [7:0] L_RESET  = 8'b100_100_01;
  localparam logic [7:0] L_MAIN_G = 8'b001_100_01;
  localparam logic [7:0] L_SIDE_G = 8'b100_001_01;
  localparam logic [7:0] L_SIDE_Y = 8'b100_010_01;
  localparam logic [7:0] L_WALK   = 8'b100_100_10;

  logic [7:0] lamps;
  assign lamps = {Main_R, Main_Y, Main_G, Side_R, Side_Y, Side_G, Walk_On, DontWalk_On};

  light_output_stage #(.ALLRED_CYCLES(4), .BLINK_HALF(2)) dut (
    .clk(clk), .Reset_n(Reset_n),
`ifdef LIGHT_LAMP_TEST_EN
    .Lamp_Test(Lamp_Test),
`endif
    .Cmd_Valid(Cmd_Valid), .Cmd_Ready(Cmd_Ready),
    .Cmd_Main(Cmd_Main), .Cmd_Side(Cmd_Side), .Cmd_Walk(Cmd_Walk),
    .Main_R(Main_R), .Main_Y(Main_Y), .Main_G(Main_G),
    .Side_R(Side_R), .Side_Y(Side_Y), .Side_G(Side_G),
    .Walk_On(Walk_On), .DontWalk_On(DontWalk_On), .Conflict_Err(Conflict_Err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time %0t exceeded limit", $time);
    $fatal(1, "watchdog expired");
  end

  // Present one command for a single rising edge.
  task automatic send(input logic [1:0] m, input logic [1:0] s, input logic [1:0] w);
    Cmd_Main  = m;
    Cmd_Side  = s;
    Cmd_Walk  = w;
    Cmd_Valid = 1'b1;
    @(posedge clk);
    #1 Cmd_Valid = 1'b0;
  endtask

  task automatic test_reset;
    Reset_n = 1'b0; Cmd_Valid = 1'b0;
    Cmd_Main = 2'b00; Cmd_Side = 2'b00; Cmd_Walk = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk) Reset_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (lamps !== L_RESET) begin
      n_fail++; $display("FAIL reset_lamps: got %b expected %b", lamps, L_RESET);
    end
    n_checks++;
    if (Cmd_Ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %b expected 1", Cmd_Ready);
    end
    n_checks++;
    if (Conflict_Err !== 1'b0) begin
      n_fail++; $display("FAIL reset_err: got %b expected 0", Conflict_Err);
    end
  endtask

  task automatic test_direct;
    send(2'b01, 2'b00, 2'b00);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (lamps !== L_MAIN_G) begin
        n_fail++; $display("FAIL direct_lamps[%0d]: got %b expected %b", i, lamps, L_MAIN_G);
      end
      n_checks++;
      if (Cmd_Ready !== 1'b1) begin
        n_fail++; $display("FAIL direct_ready[%0d]: got %b expected 1", i, Cmd_Ready);
      end
    end
  endtask

  // Main green -> side green; a different command is held valid through the clearance.
  task automatic test_interlock;
    Cmd_Main = 2'b00; Cmd_Side = 2'b01; Cmd_Walk = 2'b00; Cmd_Valid = 1'b1;
    @(posedge clk);
    #1 Cmd_Side = 2'b10;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (lamps !== L_RESET) begin
        n_fail++; $display("FAIL clear_lamps[%0d]: got %b expected %b", i, lamps, L_RESET);
      end
      n_checks++;
      if (Cmd_Ready !== 1'b0) begin
        n_fail++; $display("FAIL clear_ready[%0d]: got %b expected 0", i, Cmd_Ready);
      end
    end
    @(negedge clk);
    n_checks++;
    if (lamps !== L_SIDE_G) begin
      n_fail++; $display("FAIL clear_done_lamps: got %b expected %b", lamps, L_SIDE_G);
    end
    n_checks++;
    if (Cmd_Ready !== 1'b1) begin
      n_fail++; $display("FAIL clear_done_ready: got %b expected 1", Cmd_Ready);
    end
    @(posedge clk);
    #1 Cmd_Valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (lamps !== L_SIDE_Y) begin
      n_fail++; $display("FAIL held_cmd_lamps: got %b expected %b", lamps, L_SIDE_Y);
    end
  endtask

  task automatic test_conflict;
    send(2'b01, 2'b10, 2'b00);
    @(negedge clk);
    n_checks++;
    if (lamps !== L_SIDE_Y) begin
      n_fail++; $display("FAIL conflict_lamps: got %b expected %b", lamps, L_SIDE_Y);
    end
    n_checks++;
    if (Conflict_Err !== 1'b1) begin
      n_fail++; $display("FAIL conflict_err: got %b expected 1", Conflict_Err);
    end
    n_checks++;
    if (Cmd_Ready !== 1'b1) begin
      n_fail++; $display("FAIL conflict_ready: got %b expected 1", Cmd_Ready);
    end
    send(2'b00, 2'b00, 2'b00);
    @(negedge clk);
    n_checks++;
    if (lamps !== L_RESET) begin
      n_fail++; $display("FAIL post_conflict_lamps: got %b expected %b", lamps, L_RESET);
    end
    n_checks++;
    if (Conflict_Err !== 1'b1) begin
      n_fail++; $display("FAIL conflict_sticky: got %b expected 1", Conflict_Err);
    end
  endtask

  task automatic test_walk;
    send(2'b00, 2'b00, 2'b01);
    @(negedge clk);
    n_checks++;
    if (lamps !== L_WALK) begin
      n_fail++; $display("FAIL walk_steady: got %b expected %b", lamps, L_WALK);
    end
    send(2'b11, 2'b11, 2'b11);
    @(negedge clk);
    n_checks++;
    if (lamps !== L_RESET) begin
      n_fail++; $display("FAIL reserved_codes: got %b expected %b", lamps, L_RESET);
    end
    n_checks++;
    if (Conflict_Err !== 1'b1) begin
      n_fail++; $display("FAIL reserved_err: got %b expected 1", Conflict_Err);
    end
  endtask

  task automatic test_flash;
    logic [5:0] pat;
    logic [2:0] pat2;
    logic [7:0] exp;
    pat  = 6'b110011;
    pat2 = 3'b110;
    send(2'b00, 2'b00, 2'b10);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      exp = {6'b100100, pat[5-i], 1'b0};
      n_checks++;
      if (lamps !== exp) begin
        n_fail++; $display("FAIL flash[%0d]: got %b expected %b", i, lamps, exp);
      end
    end
    send(2'b00, 2'b00, 2'b10);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      exp = {6'b100100, pat2[2-i], 1'b0};
      n_checks++;
      if (lamps !== exp) begin
        n_fail++; $display("FAIL flash_restart[%0d]: got %b expected %b", i, lamps, exp);
      end
    end
  endtask

  task automatic test_reset_in_clear;
    send(2'b01, 2'b00, 2'b00);
    @(negedge clk);
    n_checks++;
    if (lamps !== L_MAIN_G) begin
      n_fail++; $display("FAIL pre_clear_lamps: got %b expected %b", lamps, L_MAIN_G);
    end
    send(2'b00, 2'b01, 2'b00);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (Cmd_Ready !== 1'b0) begin
      n_fail++; $display("FAIL in_clear_ready: got %b expected 0", Cmd_Ready);
    end
    #2 Reset_n = 1'b0;
    #1;
    n_checks++;
    if (lamps !== L_RESET) begin
      n_fail++; $display("FAIL async_reset_lamps: got %b expected %b", lamps, L_RESET);
    end
    n_checks++;
    if (Cmd_Ready !== 1'b1) begin
      n_fail++; $display("FAIL async_reset_ready: got %b expected 1", Cmd_Ready);
    end
    n_checks++;
    if (Conflict_Err !== 1'b0) begin
      n_fail++; $display("FAIL async_reset_err: got %b expected 0", Conflict_Err);
    end
    @(negedge clk) Reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_checks++;
      if (lamps !== L_RESET) begin
        n_fail++; $display("FAIL pending_lost[%0d]: got %b expected %b", i, lamps, L_RESET);
      end
    end
  endtask

  initial begin
    test_reset;
    test_direct;
    test_interlock;
    test_conflict;
    test_walk;
    test_flash;
    test_reset_in_clear;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
